// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store sequencing controller
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_MEM_SIZE = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        logic w_ok;
        w_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!write)
            w_ok = w_ok || (f3 == F3_BU) || (f3 == F3_HU);
        return w_ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/halfword lane extraction for loads and lane merge for stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the word read back in RD.
    always_comb begin
        o_store_word = i_word;
        case (i_funct3)
            F3_B: begin
                case (i_lane)
                    2'd0:    o_store_word[7:0]   = i_wdata[7:0];
                    2'd1:    o_store_word[15:8]  = i_wdata[7:0];
                    2'd2:    o_store_word[23:16] = i_wdata[7:0];
                    default: o_store_word[31:24] = i_wdata[7:0];
                endcase
            end
            F3_H: begin
                if (i_lane[1])
                    o_store_word[31:16] = i_wdata[15:0];
                else
                    o_store_word[15:0]  = i_wdata[15:0];
            end
            default: o_store_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer turning byte/half/word requests into aligned RAM cycles
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = LSU_MEM_SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LAST_WADDR = 32'(MEM_SIZE - 4);

    lsu_state_e  r_state;
    lsu_state_e  w_state_next;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_accept;
    logic        w_misalign;
    logic        w_req_err;
    logic [31:0] w_req_waddr;
    logic [31:0] w_word;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign req_ready   = (r_state == IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_req_waddr = {req_addr[31:2], 2'b00};

    always_comb begin
        w_misalign = 1'b0;
        case (req_funct3)
            F3_H, F3_HU: w_misalign = req_addr[0];
            F3_W:        w_misalign = |req_addr[1:0];
            default:     w_misalign = 1'b0;
        endcase
    end

    assign w_req_err = !f3_legal(req_write, req_funct3) || w_misalign
                       || (w_req_waddr > LAST_WADDR);

    // During RD the live RAM word is used so the load result can be registered
    // at the same edge that fills the buffer.
    assign w_word = (r_state == RD) ? mem_rdata : r_buf;

    lsu_lane_align u_lane_align (
        .i_word       (w_word),
        .i_lane       (r_addr[1:0]),
        .i_funct3     (r_funct3),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err)
                        w_state_next = RESP;
                    else if (req_write && (req_funct3 == F3_W))
                        w_state_next = WR;
                    else
                        w_state_next = RD;
                end
            end
            RD:      w_state_next = r_write ? WR : RESP;
            WR:      w_state_next = RESP;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_buf        <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (r_state == RD)
                r_buf <= mem_rdata;
            r_resp_valid <= (w_state_next == RESP);
            r_resp_err   <= w_accept && w_req_err;
            r_resp_rdata <= ((r_state == RD) && !r_write) ? w_load_data : 32'd0;
        end
    end

    assign mem_read   = (r_state == RD);
    assign mem_write  = (r_state == WR);
    assign mem_addr   = (mem_read || mem_write) ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = mem_write ? w_store_word : 32'd0;

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:31];
    int n_pass = 0;
    int n_chk  = 0;

    logic        o_rd [1:4];
    logic        o_wr [1:4];
    logic        o_rv [1:4];
    logic        o_err [1:4];
    logic [31:0] o_wd [1:4];
    logic [31:0] o_ad [1:4];
    logic [31:0] o_rdata [1:4];

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_SIZE(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[6:2]];
    always @(posedge clk) if (mem_write) ram[mem_addr[6:2]] <= mem_wdata;

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            o_rd[k] = mem_read; o_wr[k] = mem_write; o_rv[k] = resp_valid; o_err[k] = resp_err;
            o_wd[k] = mem_wdata; o_ad[k] = mem_addr; o_rdata[k] = resp_rdata;
        end
    endtask

    task automatic test_reset;
        logic seen;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else n_pass++;
        n_chk++; if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0000) $display("FAIL reset_strobes got %b exp 0000", {resp_valid, resp_err, mem_read, mem_write}); else n_pass++;
        n_chk++; if ((mem_addr | mem_wdata | resp_rdata) !== 32'd0) $display("FAIL reset_data got %h exp 0", mem_addr | mem_wdata | resp_rdata); else n_pass++;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_read !== 1'b1) $display("FAIL reset_pre_rd got %b exp 1", mem_read); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({mem_read, mem_write, req_ready} !== 3'b001) $display("FAIL reset_abort got %b exp 001", {mem_read, mem_write, req_ready}); else n_pass++;
        n_chk++; if (mem_addr !== 32'd0) $display("FAIL reset_abort_addr got %h exp 0", mem_addr); else n_pass++;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= resp_valid; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); seen |= resp_valid; end
        n_chk++; if (seen !== 1'b0) $display("FAIL reset_no_resp got %b exp 0", seen); else n_pass++;
    endtask

    task automatic test_sw_lw;
        issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        n_chk++; if ({o_rd[1], o_wr[1]} !== 2'b01) $display("FAIL sw_strobe got %b exp 01", {o_rd[1], o_wr[1]}); else n_pass++;
        n_chk++; if (o_wd[1] !== 32'hDEADBEEF) $display("FAIL sw_wdata got %h exp deadbeef", o_wd[1]); else n_pass++;
        n_chk++; if (o_ad[1] !== 32'h10) $display("FAIL sw_addr got %h exp 10", o_ad[1]); else n_pass++;
        n_chk++; if ({o_rv[1], o_rv[2], o_err[2], o_rv[3]} !== 4'b0100) $display("FAIL sw_resp got %b exp 0100", {o_rv[1], o_rv[2], o_err[2], o_rv[3]}); else n_pass++;
        n_chk++; if (o_rdata[2] !== 32'd0) $display("FAIL sw_rdata got %h exp 0", o_rdata[2]); else n_pass++;
        issue(1'b0, F3_W, 32'h10, 32'd0);
        n_chk++; if ({o_rd[1], o_wr[1], o_rv[1]} !== 3'b100) $display("FAIL lw_strobe got %b exp 100", {o_rd[1], o_wr[1], o_rv[1]}); else n_pass++;
        n_chk++; if (o_rv[2] !== 1'b1 || o_rdata[2] !== 32'hDEADBEEF) $display("FAIL lw_data got %b/%h exp 1/deadbeef", o_rv[2], o_rdata[2]); else n_pass++;
        n_chk++; if (o_rv[3] !== 1'b0 || o_rdata[3] !== 32'd0) $display("FAIL lw_after got %b/%h exp 0/0", o_rv[3], o_rdata[3]); else n_pass++;
    endtask

    task automatic test_sb_rmw;
        issue(1'b1, F3_B, 32'h12, 32'hFFFFFF55);
        n_chk++; if ({o_rd[1], o_wr[1], o_rd[2], o_wr[2]} !== 4'b1001) $display("FAIL sb_seq got %b exp 1001", {o_rd[1], o_wr[1], o_rd[2], o_wr[2]}); else n_pass++;
        n_chk++; if (o_wd[2] !== 32'hDE55BEEF) $display("FAIL sb_wdata got %h exp de55beef", o_wd[2]); else n_pass++;
        n_chk++; if (o_ad[2] !== 32'h10) $display("FAIL sb_addr got %h exp 10", o_ad[2]); else n_pass++;
        n_chk++; if ({o_rv[2], o_rv[3], o_err[3]} !== 3'b010) $display("FAIL sb_resp got %b exp 010", {o_rv[2], o_rv[3], o_err[3]}); else n_pass++;
        issue(1'b0, F3_B, 32'h12, 32'd0);
        n_chk++; if (o_rdata[2] !== 32'h00000055) $display("FAIL lb_12 got %h exp 00000055", o_rdata[2]); else n_pass++;
        issue(1'b0, F3_B, 32'h13, 32'd0);
        n_chk++; if (o_rdata[2] !== 32'hFFFFFFDE) $display("FAIL lb_13 got %h exp ffffffde", o_rdata[2]); else n_pass++;
        issue(1'b0, F3_BU, 32'h13, 32'd0);
        n_chk++; if (o_rdata[2] !== 32'h000000DE) $display("FAIL lbu_13 got %h exp 000000de", o_rdata[2]); else n_pass++;
    endtask

    task automatic test_halfword;
        issue(1'b1, F3_H, 32'h12, 32'h12348001);
        n_chk++; if (o_wr[2] !== 1'b1 || o_wd[2] !== 32'h8001BEEF) $display("FAIL sh_wdata got %b/%h exp 1/8001beef", o_wr[2], o_wd[2]); else n_pass++;
        n_chk++; if (o_rv[3] !== 1'b1) $display("FAIL sh_resp got %b exp 1", o_rv[3]); else n_pass++;
        issue(1'b0, F3_H, 32'h12, 32'd0);
        n_chk++; if (o_rdata[2] !== 32'hFFFF8001) $display("FAIL lh_12 got %h exp ffff8001", o_rdata[2]); else n_pass++;
        issue(1'b0, F3_HU, 32'h12, 32'd0);
        n_chk++; if (o_rdata[2] !== 32'h00008001) $display("FAIL lhu_12 got %h exp 00008001", o_rdata[2]); else n_pass++;
        issue(1'b0, F3_H, 32'h10, 32'd0);
        n_chk++; if (o_rdata[2] !== 32'hFFFFBEEF) $display("FAIL lh_10 got %h exp ffffbeef", o_rdata[2]); else n_pass++;
    endtask

    task automatic test_errors;
        logic        e_w  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  e_f3 [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] e_a  [5] = '{32'h11, 32'h13, 32'h80, 32'h10, 32'h10};
        string       e_n  [5] = '{"lw_11", "sh_13", "sw_80", "ld_f3_011", "st_f3_100"};
        logic        strobe;
        for (int i = 0; i < 5; i++) begin
            issue(e_w[i], e_f3[i], e_a[i], 32'hA5A5A5A5);
            strobe = o_rd[1] | o_rd[2] | o_rd[3] | o_wr[1] | o_wr[2] | o_wr[3];
            n_chk++; if ({o_rv[1], o_err[1], o_rv[2]} !== 3'b110) $display("FAIL err_%s_resp got %b exp 110", e_n[i], {o_rv[1], o_err[1], o_rv[2]}); else n_pass++;
            n_chk++; if (o_rdata[1] !== 32'd0 || strobe !== 1'b0) $display("FAIL err_%s_side got %h/%b exp 0/0", e_n[i], o_rdata[1], strobe); else n_pass++;
        end
        issue(1'b1, F3_W, 32'h7C, 32'h0BADCAFE);
        n_chk++; if ({o_wr[1], o_rv[2], o_err[2]} !== 3'b110) $display("FAIL sw_7c got %b exp 110", {o_wr[1], o_rv[2], o_err[2]}); else n_pass++;
        issue(1'b0, F3_W, 32'h7C, 32'd0);
        n_chk++; if (o_rdata[2] !== 32'h0BADCAFE) $display("FAIL lw_7c got %h exp 0badcafe", o_rdata[2]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic        b_w  [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  b_f3 [3] = '{F3_W, F3_W, F3_W};
        logic [31:0] b_a  [3] = '{32'h10, 32'h14, 32'h11};
        int acc_cyc [3] = '{100, 100, 100};
        int idx = 0;
        int n_resp = 0;
        int n_rdy = 0;
        logic acc;
        @(negedge clk);
        req_valid = 1'b1; req_write = b_w[0]; req_funct3 = b_f3[0]; req_addr = b_a[0]; req_wdata = 32'hCAFEF00D;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid) n_resp++;
            if (idx < 3 && req_ready) n_rdy++;
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc[idx] = c;
                idx++;
                if (idx < 3) begin
                    req_write = b_w[idx]; req_funct3 = b_f3[idx]; req_addr = b_a[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        n_chk++; if (idx !== 3) $display("FAIL b2b_accepts got %0d exp 3", idx); else n_pass++;
        n_chk++; if (n_resp !== 3) $display("FAIL b2b_resps got %0d exp 3", n_resp); else n_pass++;
        n_chk++; if (n_rdy !== 3) $display("FAIL b2b_ready_cycles got %0d exp 3", n_rdy); else n_pass++;
        n_chk++; if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) $display("FAIL b2b_spacing got %0d,%0d exp 3,3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); else n_pass++;
        n_chk++; if (ram[5] !== 32'hCAFEF00D) $display("FAIL b2b_sw_word got %h exp cafef00d", ram[5]); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_sw_lw();
        test_sb_rmw();
        test_halfword();
        test_errors();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
